pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_fetch_unit.sv | 63 ++++++
 tb/tb_pc_fetch_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch FSM encodings and branch FUNCT3 definitions.
package pc_fetch_unit_pkg;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    ERROR = 3'd4
  } fetch_state_t;
  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction
endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch with hold/retire handshake and redirect.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            take_branch,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic            misalign_err
);
  fetch_state_t state, next_state;
  logic [XLEN-1:0] pc;
  logic retire, bad_redirect;
  assign retire = state == HOLD && !stall;
  assign bad_redirect = take_branch && misaligned(target[1:0]);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end
  always_comb begin
    next_state = IDLE;
    unique case (state)
      IDLE:    next_state = REQ;
      REQ:     next_state = imem_ready ? WAIT : REQ;
      WAIT:    next_state = imem_rvalid ? HOLD : WAIT;
      HOLD:    next_state = stall ? HOLD : bad_redirect ? ERROR : REQ;
      ERROR:   next_state = ERROR;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    imem_req     = state == REQ;
    imem_addr    = pc;
    instr_valid  = state == HOLD;
    misalign_err = state == ERROR;
  end
  // Responses only land in WAIT; anything arriving elsewhere is stale and dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      instr  <= '0;
      pc_out <= '0;
    end else begin
      if (state == WAIT && imem_rvalid) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
      if (retire && !bad_redirect) pc <= take_branch ? target : pc + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch traffic against a queue-based reference with a decoupled monitor.
module tb_pc_fetch_unit;
  logic clk = 0, rst = 1, take_branch = 0, stall = 0, imem_ready = 0, imem_rvalid = 0;
  logic [31:0] target = '0, imem_rdata = '0;
  logic imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, pc_out;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .take_branch(take_branch), .target(target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .pc_out(pc_out), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t cur = '{pc: 32'h0, data: 32'h0};
  int compared = 0, mismatched = 0;

  logic [31:0] mdl_pc = 32'h0;
  bit outstanding = 0, present = 0, exp_err = 0, post_rst = 0;

  int p_ready = 100, p_rvalid = 100, p_stall = 0, p_br = 0, p_mis = 0, p_spur = 0;
  bit fix_data = 0, fix_tgt = 0;
  logic [31:0] tgt_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the fetch sequence is "next address = redirect target or previous + 4",
  // one presented instruction per accepted request, error on misaligned redirect.
  always @(posedge clk) begin
    post_rst <= rst;
    if (rst) begin
      mdl_pc <= 32'h0;
      outstanding <= 0;
      present <= 0;
      exp_err <= 0;
      exp_q.delete();
    end else if (!exp_err) begin
      if (present && !stall) begin
        present <= 0;
        if (take_branch && target[1:0] != 2'b00) exp_err <= 1;
        else mdl_pc <= take_branch ? target : mdl_pc + 32'd4;
      end
      if (outstanding && imem_rvalid) begin
        exp_q.push_back('{pc: mdl_pc, data: imem_rdata});
        outstanding <= 0;
        present <= 1;
      end
      if (imem_req && imem_ready) outstanding <= 1;
    end
  end

  always @(negedge clk) begin
    check("req_while_outstanding", {31'b0, imem_req && outstanding}, 32'h0);
    if (post_rst) begin
      check("rst_instr", instr, 32'h0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_err", {31'b0, misalign_err}, 32'h0);
    end else begin
      check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_err});
      check("instr_valid", {31'b0, instr_valid}, {31'b0, present});
      if (exp_err || present || outstanding) check("req_inactive", {31'b0, imem_req}, 32'h0);
      if (imem_req) check("imem_addr", imem_addr, mdl_pc);
      if (present) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        check("instr", instr, cur.data);
        check("pc_out", pc_out, cur.pc);
      end
    end
  end

  task automatic drive();
    logic [31:0] t;
    imem_ready  = $urandom_range(99) < p_ready;
    imem_rvalid = $urandom_range(99) < (outstanding ? p_rvalid : p_spur);
    imem_rdata  = fix_data ? 32'h0000_0013 : $urandom();
    stall       = $urandom_range(99) < p_stall;
    take_branch = $urandom_range(99) < p_br;
    t = $urandom();
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF8;
    if ($urandom_range(99) >= p_mis) t[1:0] = 2'b00;
    target = fix_tgt ? tgt_val : t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    drive();
    drive();
    rst = 0;
  endtask

  task automatic wait_sig(input bit want_req, input string name);
    int n = 0;
    while (!(want_req ? imem_req : instr_valid) && n < 50) begin
      drive();
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout, got 0 expected 1", name);
    end
  endtask

  task automatic nominal();
    p_ready = 100; p_rvalid = 100; p_stall = 0; p_br = 0; p_mis = 0; p_spur = 0;
    fix_tgt = 0;
  endtask

  bit er[9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
  bit ev[9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
  logic [31:0] a_hold;

  initial begin
    @(posedge clk);
    #1;
    // back-to-back fetch cadence from reset
    nominal();
    fix_data = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t1_req", {31'b0, imem_req}, {31'b0, er[i]});
      check("t1_valid", {31'b0, instr_valid}, {31'b0, ev[i]});
      if (er[i]) check("t1_addr", imem_addr, 32'(4 * (i / 3)));
      drive();
    end
    fix_data = 0;
    // aligned redirect
    wait_sig(0, "t2_valid");
    p_br = 100; fix_tgt = 1; tgt_val = 32'h0000_0100;
    drive();
    nominal();
    wait_sig(1, "t2_req");
    check("t2_addr", imem_addr, 32'h0000_0100);
    wait_sig(0, "t2_valid2");
    check("t2_pc_out", pc_out, 32'h0000_0100);
    // stall holds, redirect during stall ignored
    p_stall = 100; p_br = 100; fix_tgt = 1; tgt_val = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      drive();
      check("t3_req", {31'b0, imem_req}, 32'h0);
      check("t3_valid", {31'b0, instr_valid}, 32'h1);
      check("t3_pc_out", pc_out, 32'h0000_0100);
    end
    nominal();
    drive();
    // memory back-pressure
    p_ready = 0;
    wait_sig(1, "t4_req");
    a_hold = mdl_pc;
    check("t4_addr0", imem_addr, 32'h0000_0104);
    for (int i = 0; i < 4; i++) begin
      drive();
      check("t4_req", {31'b0, imem_req}, 32'h1);
      check("t4_addr", imem_addr, a_hold);
    end
    p_ready = 100;
    drive();
    check("t4_accepted", {31'b0, imem_req}, 32'h0);
    // wrap past the top of the address space
    wait_sig(0, "t7_valid");
    p_br = 100; fix_tgt = 1; tgt_val = 32'hFFFF_FFFC;
    drive();
    nominal();
    wait_sig(1, "t7_req");
    check("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_sig(0, "t7_valid2");
    drive();
    wait_sig(1, "t7_req2");
    check("t7_addr_wrap", imem_addr, 32'h0);
    // misaligned redirect is fatal until reset
    wait_sig(0, "t5_valid");
    p_br = 100; fix_tgt = 1; tgt_val = 32'h0000_0102;
    drive();
    nominal();
    for (int i = 0; i < 4; i++) begin
      drive();
      check("t5_err", {31'b0, misalign_err}, 32'h1);
      check("t5_req", {31'b0, imem_req}, 32'h0);
    end
    do_reset();
    check("t5_err_clr", {31'b0, misalign_err}, 32'h0);
    wait_sig(1, "t5_req2");
    check("t5_restart", imem_addr, 32'h0);
    // reset mid-WAIT with stale response afterwards
    p_rvalid = 0;
    drive();
    check("t6_in_wait", {31'b0, outstanding}, 32'h1);
    rst = 1;
    drive();
    rst = 0;
    p_spur = 100; p_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive();
      check("t6_valid", {31'b0, instr_valid}, 32'h0);
    end
    check("t6_addr", imem_addr, 32'h0);
    nominal();
    wait_sig(0, "t6_valid2");
    check("t6_pc_out", pc_out, 32'h0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        p_ready = $urandom_range(100, 30);
        p_rvalid = $urandom_range(100, 20);
        p_stall = $urandom_range(60);
        p_br = $urandom_range(40);
        p_mis = $urandom_range(10);
        p_spur = $urandom_range(50);
      end
      if (exp_err || $urandom_range(499) == 0) do_reset();
      else drive();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
